// File: rtl/rs_issue_select_pkg.sv
// Shared types, sizes and small helpers for the reservation-station issue scheduler.
package rs_issue_select_pkg;

    localparam int RS_SZ    = 16;
    localparam int N        = 2;
    localparam int NUM_ALU  = 2;
    localparam int NUM_MULT = 1;
    localparam int NUM_BR   = 1;
    localparam int NUM_MEM  = 1;

    localparam int IDX_W = $clog2(RS_SZ);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BR   = 2'd2,
        FU_MEM  = 2'd3
    } fu_type_e;

    typedef logic [IDX_W-1:0] rs_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic rs_idx_t onehot_to_idx(input logic [RS_SZ-1:0] oh);
        rs_idx_t idx;
        idx = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (oh[i]) idx = idx | rs_idx_t'(i);
        end
        return idx;
    endfunction

    function automatic int class_num(input int c);
        case (c)
            0:       return NUM_ALU;
            1:       return NUM_MULT;
            2:       return NUM_BR;
            default: return NUM_MEM;
        endcase
    endfunction

    // Slot-fill order: branches first, then memory, multiply, ALU.
    function automatic int prio_class(input int o);
        case (o)
            0:       return int'(FU_BR);
            1:       return int'(FU_MEM);
            2:       return int'(FU_MULT);
            default: return int'(FU_ALU);
        endcase
    endfunction

    // Free units clamped to the units that exist and to the issue width.
    function automatic cnt_t class_limit(input logic [2:0] avail, input int num);
        int lim;
        lim = int'(avail);
        if (lim > num) lim = num;
        if (lim > N) lim = N;
        return cnt_t'(lim);
    endfunction

endpackage

// File: rtl/rs_issue_select_age_pick.sv
// Oldest-requester picker: returns a one-hot grant for the requester that no other requester is older than.
module rs_issue_select_age_pick
    import rs_issue_select_pkg::*;
(
    input  logic [RS_SZ-1:0]            req,
    input  logic [RS_SZ-1:0][RS_SZ-1:0] older,
    output logic [RS_SZ-1:0]            gnt
);

    logic [RS_SZ-1:0] cand;

    // An entry is a candidate when no other requester is marked older than it.
    always_comb begin
        logic blocked;
        cand    = '0;
        blocked = 1'b0;
        for (int i = 0; i < RS_SZ; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_SZ; j++) begin
                if (j != i && req[j] && older[j][i]) blocked = 1'b1;
            end
            cand[i] = req[i] & ~blocked;
        end
    end

    // Lowest-index isolate keeps the grant one-hot even if ages were ever unordered.
    assign gnt = cand & (~cand + RS_SZ'(1));

endmodule

// File: rtl/rs_issue_select.sv
// Issue scheduler: age matrix over RS entries, oldest-first per-class selection, class-priority slot fill.
module rs_issue_select
    import rs_issue_select_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           alloc_valid,
    input  logic [N*IDX_W-1:0]     alloc_idx,
    input  logic [RS_SZ-1:0]       rs_valid,
    input  logic [RS_SZ-1:0]       rs_src_ready,
    input  logic [RS_SZ*2-1:0]     rs_fu_type,
    input  logic [RS_SZ-1:0]       rs_squash,
    input  logic [4*3-1:0]         fu_avail,
    output logic [RS_SZ-1:0]       rs_data_issuing,
    output logic [N-1:0]           issue_valid,
    output logic [N*IDX_W-1:0]     issue_idx
);

    logic [RS_SZ-1:0][RS_SZ-1:0] older_q, older_d;
    logic [RS_SZ-1:0]            class_req [4];
    logic [RS_SZ-1:0]            class_gnt [4][N];
    cnt_t                        class_lim [4];

    // Split live requesters by functional-unit class and compute per-class pick limits.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            class_lim[c] = class_limit(fu_avail[3*c +: 3], class_num(c));
            for (int i = 0; i < RS_SZ; i++) begin
                class_req[c][i] = rs_valid[i] & rs_src_ready[i] & ~rs_squash[i]
                                  & (rs_fu_type[2*i +: 2] == 2'(c));
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_cls
        for (genvar p = 0; p < N; p++) begin : g_pick
            logic [RS_SZ-1:0] preq;
            logic [RS_SZ-1:0] pgnt;
            if (p == 0) begin : g_first
                assign preq = class_req[c];
            end else begin : g_next
                assign preq = g_pick[p-1].preq & ~g_pick[p-1].pgnt;
            end
            rs_issue_select_age_pick u_pick (
                .req   (preq),
                .older (older_q),
                .gnt   (pgnt)
            );
            assign class_gnt[c][p] = pgnt;
        end
    end

    // Fill issue slots in class priority order, oldest first within a class, capped at N.
    always_comb begin
        int slot;
        int c;
        slot            = 0;
        c               = 0;
        rs_data_issuing = '0;
        issue_valid     = '0;
        issue_idx       = '0;
        for (int o = 0; o < 4; o++) begin
            c = prio_class(o);
            for (int p = 0; p < N; p++) begin
                if (!reset && slot < N && cnt_t'(p) < class_lim[c] && class_gnt[c][p] != '0) begin
                    issue_valid[slot]                 = 1'b1;
                    issue_idx[slot*IDX_W +: IDX_W]    = onehot_to_idx(class_gnt[c][p]);
                    rs_data_issuing                   = rs_data_issuing | class_gnt[c][p];
                    slot++;
                end
            end
        end
    end

    // New entries become younger than every surviving entry and than earlier same-cycle allocations.
    always_comb begin
        rs_idx_t a;
        rs_idx_t b;
        a       = '0;
        b       = '0;
        older_d = older_q;
        for (int k = 0; k < N; k++) begin
            if (alloc_valid[k]) begin
                a          = alloc_idx[k*IDX_W +: IDX_W];
                older_d[a] = '0;
                for (int j = 0; j < RS_SZ; j++) begin
                    if (rs_valid[j] && !rs_data_issuing[j] && !rs_squash[j]) older_d[j][a] = 1'b1;
                end
                for (int kk = 0; kk < k; kk++) begin
                    if (alloc_valid[kk]) begin
                        b             = alloc_idx[kk*IDX_W +: IDX_W];
                        older_d[b][a] = 1'b1;
                    end
                end
            end
        end
        if (reset) older_d = '0;
    end

    // Age matrix register; reset is folded into the next-state logic.
    always_ff @(posedge clock) begin
        older_q <= older_d;
    end

    for (genvar k = 0; k < N; k++) begin : g_chk
        a_alloc_free: assert property (@(posedge clock) disable iff (reset)
            alloc_valid[k] |-> !(rs_valid[alloc_idx[k*IDX_W +: IDX_W]]
                                 && !rs_data_issuing[alloc_idx[k*IDX_W +: IDX_W]]
                                 && !rs_squash[alloc_idx[k*IDX_W +: IDX_W]]));
    end

endmodule
